// File: rtl/iob_clint_rtc_gen_pkg.sv
// iob_clint_rtc_gen_pkg: register addresses, CTRL bit indices and reset defaults shared by the RTC generator
package iob_clint_rtc_gen_pkg;
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_DIV = 2'd1;
  localparam logic [1:0] REG_INC = 2'd2;
  localparam logic [1:0] REG_TICKS = 2'd3;
  localparam int CTRL_EN = 0;
  localparam int CTRL_CLR = 1;
  localparam int DIV_RST_DEF = 49;
  localparam int INC_RST_DEF = 'h28F5C29;
endpackage

// File: rtl/iob_clint_rtc_gen_div.sv
// iob_clint_rtc_gen_div: integer half-period counter (or phase accumulator under IOB_CLINT_RTC_FRAC_EN) driving rtc toggle and rising-edge tick; ports clk_i/arst_i/cke_i, en/clr/div/inc in, rtc/rtc_tick out
module iob_clint_rtc_gen_div #(
  parameter int DIV_W = 16,
  parameter int INC_W = 32
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             cke_i,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  input  logic [INC_W-1:0] inc,
  output logic             rtc,
  output logic             rtc_tick
);
  logic step;
`ifdef IOB_CLINT_RTC_FRAC_EN
  logic [INC_W-1:0] acc, sum;
  logic unused_div;
  assign {step, sum} = {1'b0, acc} + {1'b0, inc};
  assign unused_div = ^div;
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) acc <= '0;
    else if (cke_i) acc <= clr ? '0 : en ? sum : acc;
`else
  logic [DIV_W-1:0] cnt;
  logic unused_inc;
  assign step = cnt >= div;
  assign unused_inc = ^inc;
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) cnt <= '0;
    else if (cke_i) cnt <= clr ? '0 : !en ? cnt : step ? '0 : cnt + DIV_W'(1);
`endif
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      rtc <= 1'b0;
      rtc_tick <= 1'b0;
    end else if (cke_i) begin
      rtc <= clr ? 1'b0 : rtc ^ (en & step);
      rtc_tick <= ~clr & en & step & ~rtc;
    end
endmodule

// File: rtl/iob_clint_rtc_gen.sv
// iob_clint_rtc_gen: IOb-configured RTC source (clk_i/arst_i/cke_i, iob_avalid/addr/wdata/wstrb in, iob_rvalid/rdata/ready out, rtc/rtc_tick out); IOB_CLINT_RTC_FRAC_EN enables the INC phase accumulator
module iob_clint_rtc_gen
  import iob_clint_rtc_gen_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DIV_W = 16,
  parameter int INC_W = 32,
  parameter logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_RST_DEF),
  parameter logic [INC_W-1:0] INC_RST = INC_W'(INC_RST_DEF)
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                cke_i,
  input  logic                iob_avalid,
  input  logic [ADDR_W-1:0]   iob_addr,
  input  logic [DATA_W-1:0]   iob_wdata,
  input  logic [DATA_W/8-1:0] iob_wstrb,
  output logic                iob_rvalid,
  output logic [DATA_W-1:0]   iob_rdata,
  output logic                iob_ready,
  output logic                rtc,
  output logic                rtc_tick
);
  logic rdy, en, wr, rd, clr, unused_addr;
  logic [1:0] sel;
  logic [DIV_W-1:0] div;
  logic [INC_W-1:0] inc;
  logic [DATA_W-1:0] ticks, mask, rd_mux;
  assign sel = iob_addr[3:2];
  assign unused_addr = ^{iob_addr[ADDR_W-1:4], iob_addr[1:0]};
  assign wr = cke_i & iob_avalid & |iob_wstrb;
  assign rd = cke_i & iob_avalid & ~|iob_wstrb;
  assign clr = wr & (sel == REG_CTRL) & iob_wstrb[0] & iob_wdata[CTRL_CLR];
  assign iob_ready = rdy & cke_i;
  for (genvar i = 0; i < DATA_W/8; i++) begin : g_mask
    assign mask[8*i +: 8] = {8{iob_wstrb[i]}};
  end
  assign rd_mux = sel == REG_CTRL ? DATA_W'(en) :
                  sel == REG_DIV ? DATA_W'(div) :
                  sel == REG_INC ? DATA_W'(inc) : ticks;
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      rdy <= 1'b0;
      en <= 1'b0;
      div <= DIV_RST;
      ticks <= '0;
      iob_rvalid <= 1'b0;
      iob_rdata <= '0;
    end else if (cke_i) begin
      rdy <= 1'b1;
      iob_rvalid <= rd;
      if (rd) iob_rdata <= rd_mux;
      if (wr && sel == REG_CTRL && iob_wstrb[0]) en <= iob_wdata[CTRL_EN];
      if (wr && sel == REG_DIV) div <= DIV_W'((DATA_W'(div) & ~mask) | (iob_wdata & mask));
      ticks <= clr ? '0 : ticks + DATA_W'(rtc_tick);
    end
`ifdef IOB_CLINT_RTC_FRAC_EN
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) inc <= INC_RST;
    else if (wr && sel == REG_INC) inc <= INC_W'((DATA_W'(inc) & ~mask) | (iob_wdata & mask));
`else
  logic unused_inc_rst;
  assign inc = '0;
  assign unused_inc_rst = ^INC_RST;
`endif
  iob_clint_rtc_gen_div #(.DIV_W(DIV_W), .INC_W(INC_W)) u_div (
    .clk_i(clk_i),
    .arst_i(arst_i),
    .cke_i(cke_i),
    .en(en),
    .clr(clr),
    .div(div),
    .inc(inc),
    .rtc(rtc),
    .rtc_tick(rtc_tick)
  );
endmodule

// File: tb/tb_iob_clint_rtc_gen.sv
// tb_iob_clint_rtc_gen: directed bench with a read scoreboard for the IOb RTC generator
module tb_iob_clint_rtc_gen;
`ifdef IOB_CLINT_RTC_FRAC_EN
  localparam int INC_W = 8;
`else
  localparam int INC_W = 32;
`endif
  typedef struct {string tag; logic [31:0] exp;} rd_t;
  logic clk = 1'b0, arst = 1'b1, cke = 1'b1, avalid = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic rvalid, ready, rtc, rtc_tick;
  logic [31:0] rdata;
  int passed = 0, total = 0;
  rd_t sb[$];
  always #5 clk = ~clk;
  iob_clint_rtc_gen #(.INC_W(INC_W)) dut (
    .clk_i(clk), .arst_i(arst), .cke_i(cke), .iob_avalid(avalid), .iob_addr(addr),
    .iob_wdata(wdata), .iob_wstrb(wstrb), .iob_rvalid(rvalid), .iob_rdata(rdata),
    .iob_ready(ready), .rtc(rtc), .rtc_tick(rtc_tick)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    avalid = 1'b1; addr = a; wdata = d; wstrb = s;
    step();
    avalid = 1'b0; wstrb = '0;
  endtask
  task automatic rd(input logic [15:0] a, input logic [31:0] e, input string tag);
    avalid = 1'b1; addr = a; wstrb = '0;
    sb.push_back('{tag, e});
    step();
    avalid = 1'b0;
    chk({tag, "_rvalid"}, 32'(rvalid), 1);
  endtask
  task automatic wait_tick(input int bound, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!rtc_tick && n < bound);
    chk("tick_seen", 32'(rtc_tick), 1);
  endtask
  task automatic period8(input string tag);
    int n;
    wait_tick(64, n);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk(tag, {30'b0, rtc, rtc_tick}, {30'b0, (i % 8) < 4, i == 8});
    end
  endtask
  always @(negedge clk)
    if (rvalid === 1'b1) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        rd_t t;
        t = sb.pop_front();
        chk(t.tag, rdata, t.exp);
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    logic r, bad;
    step(2);
    chk("rst_outputs", {27'b0, rtc, rtc_tick, rvalid, ready, |rdata}, 0);
    arst = 1'b0;
    step();
    chk("ready", 32'(ready), 1);
    rd(16'h4, 49, "div_rst");
    rd(16'h0, 0, "ctrl_rst");
    step();
    chk("rvalid_idle", 32'(rvalid), 0);
    chk("rtc_idle", 32'(rtc), 0);
`ifdef IOB_CLINT_RTC_FRAC_EN
    wr(16'h8, 64);
    wr(16'h0, 3);
    period8("frac_period");
    wr(16'h8, 0);
    step(2);
    r = rtc;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      bad |= (rtc !== r) | rtc_tick;
    end
    chk("frac_inc0_hold", 32'(bad), 0);
`else
    wr(16'h4, 3);
    wr(16'h0, 1);
    period8("int_period");
    repeat (3) wait_tick(16, n);
    rd(16'hC, 4, "ticks_same_cycle");
    rd(16'hC, 5, "ticks5");
    wr(16'h4, 0);
    chk("pre_div0", 32'(rtc), 1);
    r = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      r = ~r;
      chk("div0_toggle", {30'b0, rtc, rtc_tick}, {30'b0, r, r});
    end
    wr(16'h4, 200);
    step(150);
    chk("div200_hold", 32'(rtc), 0);
    wr(16'h4, 10);
    chk("div_lower_write", 32'(rtc), 0);
    step();
    chk("div_lower_toggle", {30'b0, rtc, rtc_tick}, 32'b11);
    wr(16'h0, 0);
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      bad |= (rtc !== 1'b1) | rtc_tick;
    end
    chk("en0_freeze", 32'(bad), 0);
    wr(16'h0, 3);
    chk("clr_rtc", {30'b0, rtc, rtc_tick}, 0);
    rd(16'hC, 0, "ticks_clr");
    wait_tick(40, n);
    chk("restart_latency", n, 10);
    step();
    rd(16'hC, 1, "ticks_first");
    wr(16'h0, 2);
    wr(16'hC, 32'h55);
    rd(16'hC, 0, "ticks_ro");
    rd(16'h0, 0, "ctrl_clr_reads0");
    wr(16'h8, 32'h1234);
    rd(16'h8, 0, "inc_absent");
    wr(16'h4, 49);
    wr(16'h4, 32'hFFFF, 4'b0001);
    rd(16'h4, 32'hFF, "div_lane0");
    wr(16'h4, 32'hAB00, 4'b0010);
    rd(16'h4, 32'hABFF, "div_lane1");
    wr(16'h4, 3);
    wr(16'h0, 1);
    wait_tick(16, n);
    step();
    rd(16'h4, 3, "div3");
    step();
    chk("mid_period", 32'(rtc), 1);
    arst = 1'b1;
    #2;
    chk("arst_outputs", {27'b0, rtc, rtc_tick, rvalid, ready, |rdata}, 0);
    step(2);
    arst = 1'b0;
    step();
    rd(16'h4, 49, "div_after_arst");
    rd(16'h0, 0, "ctrl_after_arst");
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      bad |= rtc | rtc_tick;
    end
    chk("no_tick_after_arst", 32'(bad), 0);
`endif
    step(2);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
